// File: rtl/regfile_writeback_queue_pkg.sv
// regfile_pkg: shared register-bank constants and write-back entry type
package regfile_pkg;
  localparam int DATA_W = 64;
  localparam int ADDR_W = 5;
  localparam int ZERO_REG = 31;
  localparam int NUM_REGS = 32;
  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/regfile_writeback_queue_if.sv
// regfile_writeback_queue_if: producer, bank write port and bypass lookup signals
interface regfile_writeback_queue_if import regfile_pkg::*; #(
  parameter int DEPTH = 4,
  parameter int DATA_W = regfile_pkg::DATA_W,
  parameter int ADDR_W = regfile_pkg::ADDR_W
);
  logic in_valid;
  logic in_ready;
  logic [ADDR_W-1:0] in_reg;
  logic [DATA_W-1:0] in_data;
  logic rf_stall;
  logic rf_write;
  logic [ADDR_W-1:0] rf_reg;
  logic [DATA_W-1:0] rf_data;
  logic [ADDR_W-1:0] lk1_reg;
  logic lk1_hit;
  logic [DATA_W-1:0] lk1_data;
  logic [ADDR_W-1:0] lk2_reg;
  logic lk2_hit;
  logic [DATA_W-1:0] lk2_data;
  logic [$clog2(DEPTH):0] count;
  logic empty;
  modport master (
    output in_valid, in_reg, in_data, rf_stall, lk1_reg, lk2_reg,
    input in_ready, rf_write, rf_reg, rf_data, lk1_hit, lk1_data, lk2_hit, lk2_data, count, empty
  );
  modport slave (
    input in_valid, in_reg, in_data, rf_stall, lk1_reg, lk2_reg,
    output in_ready, rf_write, rf_reg, rf_data, lk1_hit, lk1_data, lk2_hit, lk2_data, count, empty
  );
endinterface

// File: rtl/regfile_writeback_queue_bypass.sv
// wb_bypass_match: youngest-first search of queued writes for one read port
module wb_bypass_match import regfile_pkg::*; #(
  parameter int DEPTH = 4,
  parameter int DATA_W = regfile_pkg::DATA_W,
  parameter int ADDR_W = regfile_pkg::ADDR_W,
  parameter int ZERO_REG = regfile_pkg::ZERO_REG
) (
  input  logic [DEPTH-1:0]         valid_i,
  input  logic [ADDR_W-1:0]        reg_i [DEPTH],
  input  logic [DATA_W-1:0]        data_i [DEPTH],
  input  logic [$clog2(DEPTH)-1:0] tail_i,
  input  logic [ADDR_W-1:0]        key_i,
  output logic                     hit_o,
  output logic [DATA_W-1:0]        data_o
);
  localparam int PW = $clog2(DEPTH);
  logic [PW-1:0] idx;
  // Walk oldest to youngest from the tail so the youngest match overwrites older ones
  always_comb begin
    hit_o = 1'b0;
    data_o = '0;
    idx = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      idx = tail_i - PW'(k);
      if (valid_i[idx] && reg_i[idx] == key_i && key_i != ADDR_W'(ZERO_REG)) begin
        hit_o = 1'b1;
        data_o = data_i[idx];
      end
    end
  end
endmodule

// File: rtl/regfile_writeback_queue.sv
// regfile_writeback_queue: in-order write-back buffer draining into the register bank with bypass lookups
module regfile_writeback_queue import regfile_pkg::*; #(
  parameter int DEPTH = 4,
  parameter int DATA_W = regfile_pkg::DATA_W,
  parameter int ADDR_W = regfile_pkg::ADDR_W,
  parameter int ZERO_REG = regfile_pkg::ZERO_REG
) (
  input logic clk_i,
  input logic rst_ni,
  regfile_writeback_queue_if.slave wb
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [ADDR_W-1:0] reg_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic pop, ready, enq;
  // Drain the head unless stalled; a pop frees a slot for the same-cycle push; XZR writes are acknowledged but dropped
  always_comb begin
    pop = count_q != '0 && !wb.rf_stall;
    ready = count_q < CW'(DEPTH) || pop;
    enq = wb.in_valid && ready && wb.in_reg != ADDR_W'(ZERO_REG);
    head_d = pop ? head_q + 1'b1 : head_q;
    tail_d = enq ? tail_q + 1'b1 : tail_q;
    count_d = count_q + CW'(enq) - CW'(pop);
    valid_d = valid_q;
    if (pop) valid_d[head_q] = 1'b0;
    if (enq) valid_d[tail_q] = 1'b1;
  end
  // Control state clears asynchronously so a reset drops rf_write and all bypass hits at once
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end
  // Payload is never reset; the valid bits and count gate every use of it
  always_ff @(posedge clk_i) begin
    if (enq) begin
      reg_q[tail_q] <= wb.in_reg;
      data_q[tail_q] <= wb.in_data;
    end
  end
  assign wb.in_ready = ready;
  assign wb.rf_write = pop;
  assign wb.rf_reg = count_q == '0 ? '0 : reg_q[head_q];
  assign wb.rf_data = count_q == '0 ? '0 : data_q[head_q];
  assign wb.count = count_q;
  assign wb.empty = count_q == '0;
  wb_bypass_match #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG)) u_lk1 (
    .valid_i(valid_q), .reg_i(reg_q), .data_i(data_q), .tail_i(tail_q),
    .key_i(wb.lk1_reg), .hit_o(wb.lk1_hit), .data_o(wb.lk1_data)
  );
  wb_bypass_match #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG)) u_lk2 (
    .valid_i(valid_q), .reg_i(reg_q), .data_i(data_q), .tail_i(tail_q),
    .key_i(wb.lk2_reg), .hit_o(wb.lk2_hit), .data_o(wb.lk2_data)
  );
endmodule

// File: tb/tb_regfile_writeback_queue.sv
// tb_regfile_writeback_queue: queue-model checked random and directed stimulus for the write-back queue
module tb_regfile_writeback_queue;
  import regfile_pkg::*;
  localparam int DEPTH = 4;
  typedef struct {
    logic [4:0]  r;
    logic [63:0] d;
  } ent_t;
  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  ent_t q[$];
  int n_cmp = 0;
  int n_bad = 0;
  regfile_writeback_queue_if #(.DEPTH(DEPTH)) bus();
  regfile_writeback_queue #(.DEPTH(DEPTH)) dut (.clk_i(clk_i), .rst_ni(rst_ni), .wb(bus.slave));
  always #5 clk_i = ~clk_i;
  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endfunction
  // Youngest queued write to key wins; XZR never hits; result is {hit, data}
  function automatic logic [64:0] look(logic [4:0] k);
    if (k == 5'(ZERO_REG)) return '0;
    for (int i = q.size() - 1; i >= 0; i--)
      if (q[i].r == k) return {1'b1, q[i].d};
    return '0;
  endfunction
  // Reference queue: pop the oldest when not stalled, append accepted non-XZR writes
  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) q.delete();
    else begin
      bit p, a;
      p = q.size() > 0 && !bus.rf_stall;
      a = bus.in_valid && (q.size() < DEPTH || p);
      if (p) void'(q.pop_front());
      if (a && bus.in_reg != 5'(ZERO_REG)) q.push_back('{bus.in_reg, bus.in_data});
    end
  end
  // Every cycle, all outputs must match what the reference queue implies
  always @(negedge clk_i) begin
    logic [64:0] l1, l2;
    bit p;
    p = q.size() > 0 && !bus.rf_stall;
    l1 = look(bus.lk1_reg);
    l2 = look(bus.lk2_reg);
    chk("count", 64'(bus.count), 64'(q.size()));
    chk("empty", bus.empty, q.size() == 0);
    chk("rf_write", bus.rf_write, p);
    chk("rf_reg", bus.rf_reg, q.size() > 0 ? q[0].r : 5'd0);
    chk("rf_data", bus.rf_data, q.size() > 0 ? q[0].d : 64'd0);
    chk("in_ready", bus.in_ready, q.size() < DEPTH || p);
    chk("lk1_hit", bus.lk1_hit, l1[64]);
    chk("lk1_data", bus.lk1_data, l1[63:0]);
    chk("lk2_hit", bus.lk2_hit, l2[64]);
    chk("lk2_data", bus.lk2_data, l2[63:0]);
  end
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask
  task automatic put(logic v, logic [4:0] r, logic [63:0] d);
    bus.in_valid = v;
    bus.in_reg = r;
    bus.in_data = d;
  endtask
  function automatic logic [4:0] rreg();
    int r;
    r = $urandom_range(0, 9);
    return r == 9 ? 5'(ZERO_REG) : 5'(r);
  endfunction
  initial begin
    put(0, 0, 0);
    bus.rf_stall = 0;
    bus.lk1_reg = 0;
    bus.lk2_reg = 0;
    #1;
    chk("rst_write", bus.rf_write, 0);
    chk("rst_empty", bus.empty, 1);
    chk("rst_ready", bus.in_ready, 1);
    chk("rst_count", 64'(bus.count), 0);
    chk("rst_lk1", bus.lk1_hit, 0);
    chk("rst_rfdata", bus.rf_data, 0);
    repeat (2) @(posedge clk_i);
    #2 rst_ni = 1;
    step();
    put(1, 5, 64'hAA);
    step();
    put(0, 0, 0);
    #1;
    chk("t1_write", bus.rf_write, 1);
    chk("t1_reg", bus.rf_reg, 5);
    chk("t1_data", bus.rf_data, 64'hAA);
    step();
    chk("t1_empty", bus.empty, 1);
    bus.rf_stall = 1;
    for (int i = 1; i <= 4; i++) begin
      put(1, 5'(i), 64'(i * 'h11));
      step();
    end
    put(1, 9, 64'h55);
    #1;
    chk("t2_count", 64'(bus.count), 4);
    chk("t2_ready", bus.in_ready, 0);
    step();
    chk("t2_held", 64'(bus.count), 4);
    bus.rf_stall = 0;
    #1;
    chk("t2_first", bus.rf_reg, 1);
    chk("t2_ready_pop", bus.in_ready, 1);
    step();
    put(0, 0, 0);
    #1;
    chk("t2_second", bus.rf_reg, 2);
    chk("t2_count_acc", 64'(bus.count), 4);
    step();
    chk("t2_third", bus.rf_reg, 3);
    step();
    chk("t2_fourth", bus.rf_reg, 4);
    step();
    chk("t2_fifth", bus.rf_data, 64'h55);
    step();
    chk("t2_empty", bus.empty, 1);
    put(1, 31, 64'hFF);
    bus.lk1_reg = 31;
    #1;
    chk("t3_ready", bus.in_ready, 1);
    step();
    put(0, 0, 0);
    #1;
    chk("t3_count", 64'(bus.count), 0);
    chk("t3_write", bus.rf_write, 0);
    chk("t3_hit", bus.lk1_hit, 0);
    bus.rf_stall = 1;
    put(1, 7, 64'h1);
    step();
    put(1, 7, 64'h2);
    step();
    put(0, 0, 0);
    bus.lk1_reg = 7;
    #1;
    chk("t4_hit", bus.lk1_hit, 1);
    chk("t4_data", bus.lk1_data, 64'h2);
    bus.rf_stall = 0;
    #1;
    chk("t4_pop1", bus.rf_data, 64'h1);
    chk("t4_lk_pop1", bus.lk1_data, 64'h2);
    step();
    chk("t4_lk_pop2", bus.lk1_data, 64'h2);
    step();
    chk("t4_gone", bus.lk1_hit, 0);
    bus.rf_stall = 1;
    for (int i = 0; i < 4; i++) begin
      put(1, 5'($urandom_range(0, 30)), {$urandom, $urandom});
      step();
    end
    bus.rf_stall = 0;
    for (int i = 0; i < 20; i++) begin
      put(1, 5'($urandom_range(0, 30)), {$urandom, $urandom});
      bus.lk1_reg = rreg();
      bus.lk2_reg = rreg();
      #1;
      chk("t5_steady", 64'(bus.count), 4);
      step();
    end
    put(0, 0, 0);
    repeat (6) step();
    bus.rf_stall = 1;
    for (int i = 0; i < 3; i++) begin
      put(1, 5'(10 + i), 64'(i));
      step();
    end
    put(0, 0, 0);
    bus.rf_stall = 0;
    #1;
    chk("t6_write", bus.rf_write, 1);
    chk("t6_count", 64'(bus.count), 3);
    rst_ni = 0;
    #1;
    chk("t6_rst_write", bus.rf_write, 0);
    chk("t6_rst_count", 64'(bus.count), 0);
    chk("t6_rst_empty", bus.empty, 1);
    @(negedge clk_i);
    #1 rst_ni = 1;
    step();
    put(1, 6, 64'h66);
    step();
    put(0, 0, 0);
    #1;
    chk("t6_after_write", bus.rf_write, 1);
    chk("t6_after_reg", bus.rf_reg, 6);
    chk("t6_after_data", bus.rf_data, 64'h66);
    step();
    for (int i = 0; i < 3000; i++) begin
      put($urandom_range(0, 3) != 0, rreg(), {$urandom, $urandom});
      bus.rf_stall = $urandom_range(0, 3) == 0;
      bus.lk1_reg = rreg();
      bus.lk2_reg = rreg();
      if ($urandom_range(0, 499) == 0) begin
        rst_ni = 0;
        #2 rst_ni = 1;
      end
      step();
    end
    put(0, 0, 0);
    bus.rf_stall = 0;
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
